// File: rtl/tx_lane_scheduler_if.sv
// tx_lane_scheduler_if
//   Groups the lane-side handshakes, the far-end status and the serializer /
//   recirculation outputs of tx_lane_scheduler into one bundle.
//   master : lane sources and the far-end status (drive lanes and active)
//   slave  : the scheduler (drives ready_out*, data_out, valid_out, lane_out,
//            recirc_data, recirc_valid, tx_count)
interface tx_lane_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              valid_in0, valid_in1, valid_in2, valid_in3;
  logic              ready_out0, ready_out1, ready_out2, ready_out3;
  logic              active;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        lane_out;
  logic [DATA_W-1:0] recirc_data;
  logic              recirc_valid;
  logic [CNT_W-1:0]  tx_count;

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output active,
    input  ready_out0, ready_out1, ready_out2, ready_out3,
    input  data_out, valid_out, lane_out, recirc_data, recirc_valid, tx_count
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  active,
    output ready_out0, ready_out1, ready_out2, ready_out3,
    output data_out, valid_out, lane_out, recirc_data, recirc_valid, tx_count
  );
endinterface

// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler
//   Round-robin scheduler merging four byte lanes into the PHY TX serializer
//   stream at clk_4f. Each lane has a one-deep holding register; one held
//   byte is granted per cycle. With the far end active the byte goes to
//   data_out, otherwise it is diverted to recirc_data while data_out idles.
// Ports
//   clk_4f : block clock (four byte slots per clk_f period)
//   reset  : asynchronous, active-low
//   bus    : tx_lane_scheduler_if.slave (lane handshakes, active, outputs)
module tx_lane_scheduler #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM = 8'hBC,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  tx_lane_scheduler_if.slave   bus
);

  logic [3:0]        valid_in;
  logic [3:0]        ready;
  logic [3:0]        grant;
  logic [3:0]        hold_v;
  logic [DATA_W-1:0] din    [4];
  logic [DATA_W-1:0] hold_d [4];
  logic [1:0]        ptr;
  logic [1:0]        scan_idx;
  logic [1:0]        gnt_idx;
  logic              gnt_any;

  logic [DATA_W-1:0] data_out_q;
  logic              valid_out_q;
  logic [1:0]        lane_out_q;
  logic [DATA_W-1:0] recirc_data_q;
  logic              recirc_valid_q;
  logic [CNT_W-1:0]  tx_count_q;

  assign valid_in = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign din[0]   = bus.data_in0;
  assign din[1]   = bus.data_in1;
  assign din[2]   = bus.data_in2;
  assign din[3]   = bus.data_in3;

  // Scan from ptr upward (mod 4); the first holding lane wins.
  // NOTE: every variable written here gets a default at the top of the block,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = ptr;
    scan_idx = ptr;
    grant    = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + k[1:0];
      if (!gnt_any && hold_v[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // A lane being granted this cycle frees its slot for a new byte at the
  // same edge, which sustains one byte per cycle on a single lane.
  assign ready = ~hold_v | grant;

  assign bus.ready_out0 = ready[0];
  assign bus.ready_out1 = ready[1];
  assign bus.ready_out2 = ready[2];
  assign bus.ready_out3 = ready[3];

  // NOTE: hold_d is datapath only and is qualified by hold_v, so it carries
  // no reset; dropping hold_v is enough to discard held bytes.
  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < 4; i++) begin
      if (valid_in[i] && ready[i]) hold_d[i] <= din[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of grant/ready computed above.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      hold_v         <= '0;
      ptr            <= '0;
      data_out_q     <= IDLE_SYM;
      valid_out_q    <= 1'b0;
      lane_out_q     <= '0;
      recirc_data_q  <= '0;
      recirc_valid_q <= 1'b0;
      tx_count_q     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i] && ready[i]) hold_v[i] <= 1'b1;
        else if (grant[i])           hold_v[i] <= 1'b0;
      end

      if (gnt_any) begin
        ptr        <= gnt_idx + 2'd1;
        lane_out_q <= gnt_idx;
        if (bus.active) begin
          data_out_q     <= hold_d[gnt_idx];
          valid_out_q    <= 1'b1;
          recirc_valid_q <= 1'b0;
          tx_count_q     <= tx_count_q + 1'b1;
        end else begin
          recirc_data_q  <= hold_d[gnt_idx];
          recirc_valid_q <= 1'b1;
          data_out_q     <= IDLE_SYM;
          valid_out_q    <= 1'b0;
        end
      end else begin
        // recirc_data and lane_out keep the last granted byte's values.
        data_out_q     <= IDLE_SYM;
        valid_out_q    <= 1'b0;
        recirc_valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.lane_out     = lane_out_q;
  assign bus.recirc_data  = recirc_data_q;
  assign bus.recirc_valid = recirc_valid_q;
  assign bus.tx_count     = tx_count_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// tb_tx_lane_scheduler
//   Directed bench for tx_lane_scheduler. Inputs change and outputs are
//   sampled on the falling edge of clk_4f; the design acts on the rising edge.
module tb_tx_lane_scheduler;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   tx_exp = 0;

  always #5 clk_4f = ~clk_4f;

  tx_lane_scheduler_if #(.DATA_W(8), .CNT_W(16)) bus ();

  tx_lane_scheduler #(.DATA_W(8), .IDLE_SYM(8'hBC), .CNT_W(16)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  task automatic step();
    @(posedge clk_4f);
    @(negedge clk_4f);
  endtask

  task automatic lanes_off();
    bus.valid_in0 = 1'b0; bus.valid_in1 = 1'b0;
    bus.valid_in2 = 1'b0; bus.valid_in3 = 1'b0;
  endtask

  function automatic logic [3:0] ready_vec();
    return {bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0};
  endfunction

  task automatic test_reset();
    bus.data_in0 = 8'hA0; bus.data_in1 = 8'hA1; bus.data_in2 = 8'hA2; bus.data_in3 = 8'hA3;
    bus.valid_in0 = 1'b1; bus.valid_in1 = 1'b1; bus.valid_in2 = 1'b1; bus.valid_in3 = 1'b1;
    bus.active = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.data_out !== 8'hBC) begin errors++; $display("FAIL reset_async_data got=%h want=bc", bus.data_out); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_async_valid got=%b want=0", bus.valid_out); end
    checks++; if (bus.tx_count !== 16'h0) begin errors++; $display("FAIL reset_async_count got=%h want=0000", bus.tx_count); end
    repeat (3) step();
    checks++; if (ready_vec() !== 4'b1111) begin errors++; $display("FAIL reset_ready got=%b want=1111", ready_vec()); end
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC) begin errors++; $display("FAIL reset_hold_out got=%b/%h want=0/bc", bus.valid_out, bus.data_out); end
    checks++; if (bus.recirc_valid !== 1'b0 || bus.recirc_data !== 8'h00 || bus.lane_out !== 2'd0) begin errors++; $display("FAIL reset_recirc got=%b/%h/%0d want=0/00/0", bus.recirc_valid, bus.recirc_data, bus.lane_out); end
    lanes_off();
    reset = 1'b1;
    repeat (3) begin
      step();
      checks++; if (bus.valid_out !== 1'b0 || bus.recirc_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got=%b/%b want=0/0", bus.valid_out, bus.recirc_valid); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_b [4];
    exp_b = '{8'hEE, 8'h01, 8'hFF, 8'hFD};
    bus.active = 1'b1;
    bus.data_in0 = 8'hEE; bus.data_in1 = 8'h01; bus.data_in2 = 8'hFF; bus.data_in3 = 8'hFD;
    bus.valid_in0 = 1'b1; bus.valid_in1 = 1'b1; bus.valid_in2 = 1'b1; bus.valid_in3 = 1'b1;
    step();
    lanes_off();
    checks++; if (ready_vec() !== 4'b0001) begin errors++; $display("FAIL burst_ready got=%b want=0001", ready_vec()); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL burst_latency got=%b want=0", bus.valid_out); end
    for (int k = 0; k < 4; k++) begin
      step();
      tx_exp++;
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp_b[k] || bus.lane_out !== k[1:0]) begin
        errors++; $display("FAIL burst_beat%0d got=%b/%h/%0d want=1/%h/%0d", k, bus.valid_out, bus.data_out, bus.lane_out, exp_b[k], k);
      end
    end
    step();
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC) begin errors++; $display("FAIL burst_idle got=%b/%h want=0/bc", bus.valid_out, bus.data_out); end
    checks++; if (bus.tx_count !== 16'd4) begin errors++; $display("FAIL burst_count got=%0d want=4", bus.tx_count); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      bus.valid_in2 = 1'b1;
      bus.data_in2  = 8'h10 + 8'(k);
      checks++; if (bus.ready_out2 !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got=%b want=1", k, bus.ready_out2); end
      step();
      if (k > 0) begin
        tx_exp++;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h10 + 8'(k - 1) || bus.lane_out !== 2'd2) begin
          errors++; $display("FAIL stream_beat%0d got=%b/%h/%0d want=1/%h/2", k - 1, bus.valid_out, bus.data_out, bus.lane_out, 8'h10 + 8'(k - 1));
        end
      end
    end
    lanes_off();
    step();
    tx_exp++;
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h13) begin errors++; $display("FAIL stream_last got=%b/%h want=1/13", bus.valid_out, bus.data_out); end
    step();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b want=0", bus.valid_out); end
    checks++; if (bus.tx_count !== 16'(tx_exp)) begin errors++; $display("FAIL stream_count got=%0d want=%0d", bus.tx_count, tx_exp); end
  endtask

  task automatic test_fairness();
    logic [7:0] q0[$];
    logic [7:0] q3[$];
    logic [7:0] exp_d;
    int n0 = 0, n3 = 0, low0 = 0, low3 = 0, max_low = 0, n_out = 0;
    logic [1:0] prev_lane = 2'd0;
    bus.active = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.valid_out === 1'b1) begin
        n_out++;
        tx_exp++;
        checks++;
        if (bus.lane_out === 2'd0 && q0.size() > 0) exp_d = q0.pop_front();
        else if (bus.lane_out === 2'd3 && q3.size() > 0) exp_d = q3.pop_front();
        else exp_d = 8'hxx;
        if (bus.data_out !== exp_d) begin errors++; $display("FAIL fair_data cyc%0d lane=%0d got=%h want=%h", c, bus.lane_out, bus.data_out, exp_d); end
        if (n_out > 1) begin
          checks++; if (bus.lane_out === prev_lane) begin errors++; $display("FAIL fair_alternate cyc%0d got=%0d want!=%0d", c, bus.lane_out, prev_lane); end
        end
        prev_lane = bus.lane_out;
      end
      if (c < 12) begin
        low0 = bus.ready_out0 ? 0 : low0 + 1;
        low3 = bus.ready_out3 ? 0 : low3 + 1;
        if (low0 > max_low) max_low = low0;
        if (low3 > max_low) max_low = low3;
        bus.valid_in0 = 1'b1; bus.data_in0 = 8'h40 + 8'(n0);
        bus.valid_in3 = 1'b1; bus.data_in3 = 8'h80 + 8'(n3);
        if (bus.ready_out0) begin q0.push_back(bus.data_in0); n0++; end
        if (bus.ready_out3) begin q3.push_back(bus.data_in3); n3++; end
      end else begin
        lanes_off();
      end
      step();
    end
    checks++; if (max_low > 2) begin errors++; $display("FAIL fair_ready_low got=%0d want<=2", max_low); end
    checks++; if (q0.size() != 0 || q3.size() != 0) begin errors++; $display("FAIL fair_drain got=%0d/%0d want=0/0", q0.size(), q3.size()); end
    checks++; if (n_out != n0 + n3 || n_out < 10) begin errors++; $display("FAIL fair_total got=%0d want=%0d", n_out, n0 + n3); end
    checks++; if (bus.tx_count !== 16'(tx_exp)) begin errors++; $display("FAIL fair_count got=%0d want=%0d", bus.tx_count, tx_exp); end
  endtask

  task automatic test_divert();
    logic [7:0] obs_d[$];
    logic       obs_p[$];
    bus.active = 1'b0;
    bus.valid_in1 = 1'b1; bus.data_in1 = 8'h55;
    step();
    lanes_off();
    step();
    checks++; if (bus.recirc_valid !== 1'b1 || bus.recirc_data !== 8'h55 || bus.lane_out !== 2'd1) begin errors++; $display("FAIL divert_recirc got=%b/%h/%0d want=1/55/1", bus.recirc_valid, bus.recirc_data, bus.lane_out); end
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC) begin errors++; $display("FAIL divert_idle got=%b/%h want=0/bc", bus.valid_out, bus.data_out); end
    checks++; if (bus.tx_count !== 16'(tx_exp)) begin errors++; $display("FAIL divert_count got=%0d want=%0d", bus.tx_count, tx_exp); end
    step();
    checks++; if (bus.recirc_valid !== 1'b0 || bus.recirc_data !== 8'h55) begin errors++; $display("FAIL divert_hold got=%b/%h want=0/55", bus.recirc_valid, bus.recirc_data); end
    // Byte k is granted one edge after it is accepted; active flips before
    // the edge that grants byte 3, so bytes 0..2 recirculate, 3..7 are sent.
    for (int k = 0; k < 12; k++) begin
      if (bus.valid_out === 1'b1 && bus.recirc_valid === 1'b1) begin
        checks++; errors++; $display("FAIL divert_both cyc%0d got=1/1 want=one", k);
      end
      if (bus.valid_out === 1'b1)    begin obs_d.push_back(bus.data_out);    obs_p.push_back(1'b1); end
      if (bus.recirc_valid === 1'b1) begin obs_d.push_back(bus.recirc_data); obs_p.push_back(1'b0); end
      if (k < 8) begin
        bus.valid_in1 = 1'b1; bus.data_in1 = 8'h60 + 8'(k);
        bus.active = (k >= 4);
      end else begin
        lanes_off();
      end
      step();
    end
    checks++;
    if (obs_d.size() != 8) begin
      errors++; $display("FAIL divert_once got=%0d want=8", obs_d.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (obs_d[j] !== 8'h60 + 8'(j) || obs_p[j] !== (j >= 3)) begin
          errors++; $display("FAIL divert_seq%0d got=%h/port%b want=%h/port%b", j, obs_d[j], obs_p[j], 8'h60 + 8'(j), (j >= 3));
        end
      end
    end
    tx_exp += 5;
    checks++; if (bus.tx_count !== 16'(tx_exp)) begin errors++; $display("FAIL divert_count2 got=%0d want=%0d", bus.tx_count, tx_exp); end
  endtask

  task automatic test_reset_mid_and_wrap();
    bus.active = 1'b1;
    bus.data_in0 = 8'hC0; bus.data_in1 = 8'hC1; bus.data_in2 = 8'hC2; bus.data_in3 = 8'hC3;
    bus.valid_in0 = 1'b1; bus.valid_in1 = 1'b1; bus.valid_in2 = 1'b1; bus.valid_in3 = 1'b1;
    step();
    lanes_off();
    step();
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b want=1", bus.valid_out); end
    reset = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC || bus.lane_out !== 2'd0) begin errors++; $display("FAIL midrst_out got=%b/%h/%0d want=0/bc/0", bus.valid_out, bus.data_out, bus.lane_out); end
    checks++; if (ready_vec() !== 4'b1111 || bus.tx_count !== 16'h0) begin errors++; $display("FAIL midrst_state got=%b/%h want=1111/0000", ready_vec(), bus.tx_count); end
    @(negedge clk_4f);
    reset = 1'b1;
    tx_exp = 0;
    repeat (5) begin
      step();
      checks++; if (bus.valid_out !== 1'b0 || bus.recirc_valid !== 1'b0) begin errors++; $display("FAIL midrst_flushed got=%b/%b want=0/0", bus.valid_out, bus.recirc_valid); end
    end
    bus.valid_in0 = 1'b1; bus.data_in0 = 8'hD0;
    bus.valid_in3 = 1'b1; bus.data_in3 = 8'hD3;
    step();
    lanes_off();
    step();
    checks++; if (bus.valid_out !== 1'b1 || bus.lane_out !== 2'd0 || bus.data_out !== 8'hD0) begin errors++; $display("FAIL midrst_restart0 got=%b/%0d/%h want=1/0/d0", bus.valid_out, bus.lane_out, bus.data_out); end
    step();
    checks++; if (bus.valid_out !== 1'b1 || bus.lane_out !== 2'd3 || bus.data_out !== 8'hD3) begin errors++; $display("FAIL midrst_restart3 got=%b/%0d/%h want=1/3/d3", bus.valid_out, bus.lane_out, bus.data_out); end
    step();
    force dut.tx_count_q = 16'hFFFF;
    #1 release dut.tx_count_q;
    bus.valid_in0 = 1'b1; bus.data_in0 = 8'h77;
    step();
    lanes_off();
    checks++; if (bus.tx_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffff", bus.tx_count); end
    step();
    checks++; if (bus.tx_count !== 16'h0000 || bus.data_out !== 8'h77) begin errors++; $display("FAIL wrap_zero got=%h/%h want=0000/77", bus.tx_count, bus.data_out); end
  endtask

  initial begin
    lanes_off();
    bus.data_in0 = '0; bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
    bus.active = 1'b0;
    test_reset();
    test_burst();
    test_stream();
    test_fairness();
    test_divert();
    test_reset_mid_and_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_lane_scheduler.md
Name: tx_lane_scheduler

Overview:
Round-robin scheduler between the four 8-bit transmit lanes and the single byte stream into the PHY TX serializer, clocked at clk_4f (four byte slots per clk_f period).
- Each lane has a one-deep holding register with a valid/ready handshake.
- While the far end reports active, granted bytes go to the serializer.
- While inactive, granted bytes are diverted to the recirculation path and the serializer receives the idle symbol.

Parameters:
DATA_W, 8, lane and output byte width
IDLE_SYM, 8'hBC, symbol driven on data_out when no byte is sent
CNT_W, 16, width of tx_count

Ports:
clk_4f  in  1  single clock for the whole block
reset  in  1  asynchronous, active-low reset
data_in0..data_in3  in  DATA_W each  lane bytes
valid_in0..valid_in3  in  1 each  lane byte valid
ready_out0..ready_out3  out  1 each  lane may present a byte this cycle
active  in  1  far-end receiver active (PSRX); 1 = send to serializer, 0 = recirculate
data_out  out  DATA_W  byte to serializer
valid_out  out  1  data_out carries a lane byte
lane_out  out  2  lane index of the current data_out/recirc_data byte
recirc_data  out  DATA_W  diverted byte
recirc_valid  out  1  recirc_data valid
tx_count  out  CNT_W  number of beats with valid_out=1

Behaviour:
- Clock and reset: one clock, clk_4f. Reset is asynchronous, active-low, named reset.
- Reset values (reset=0), applied immediately:
  - all hold_v=0 and ptr=0
  - data_out=IDLE_SYM, valid_out=0, lane_out=0
  - recirc_data=0, recirc_valid=0
  - tx_count=0
  - ready_out0..3=1
- Holding register per lane i: hold_v[i] and hold_d[i].
  - ready_out[i] = !hold_v[i] | grant[i], combinational.
  - Accept when valid_in[i] & ready_out[i]: hold_d[i] <= data_in[i], hold_v[i] <= 1.
  - Grant without accept: hold_v[i] <= 0.
  - Grant and accept in the same cycle: new byte loaded, hold_v[i] stays 1. Sustains one byte per cycle per lane.
  - valid_in while not ready: ignored. The lane must hold its data.
- Arbitration, each clock edge:
  - Scan lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4). Grant the first lane with hold_v=1.
  - Only one grant per cycle.
  - On a grant: ptr <= (granted index + 1) mod 4, wrapping 3 -> 0.
  - No lane holding: no grant, ptr unchanged.
- Output routing (registered outputs, all updated on the same edge):
  - Grant with active=1: data_out <= hold_d, valid_out <= 1, lane_out <= idx, recirc_valid <= 0.
  - Grant with active=0: recirc_data <= hold_d, recirc_valid <= 1, lane_out <= idx, data_out <= IDLE_SYM, valid_out <= 0.
  - No grant: data_out <= IDLE_SYM, valid_out <= 0, recirc_valid <= 0. recirc_data and lane_out hold their values.
  - active is sampled at the same edge as the grant. A change of active affects the byte granted at that edge, with no bytes lost or duplicated.
- Latency:
  - Holding register to output: 1 cycle.
  - valid_in accepted at edge N appears on data_out at edge N+1 at the earliest.
- tx_count:
  - Increments on each edge where valid_out is set to 1.
  - Wraps from all-ones to 0.
  - Recirculated bytes do not count.
- Fairness: a lane holding a byte is granted within 4 cycles.
- Reset mid-operation: held bytes are discarded and the scheduler restarts from lane 0.

Test Plan:
1. Reset: hold reset=0 with valid_in=1111 -> data_out=8'hBC, valid_out=0, ready_out=1111, tx_count=0. No accept takes effect while reset is low.
2. Burst: active=1; one cycle with lanes 0..3 = EE,01,FF,FD -> valid_out=1 for 4 consecutive cycles with data_out EE,01,FF,FD and lane_out 0,1,2,3; then BC with valid_out=0; tx_count=4.
3. Single-lane streaming: lane2 sends 10,11,12,13 back-to-back -> data_out 10..13 on consecutive cycles; ready_out2 stays 1.
4. Fairness: lanes 0 and 3 valid continuously -> lane_out alternates 0,3,0,3; neither ready_out stays low for more than 2 cycles.
5. Diversion: active=0, lane1 sends 55 -> recirc_data=55, recirc_valid=1, lane_out=1; data_out=BC, valid_out=0; tx_count unchanged. Toggle active=1 mid-stream and check that each byte appears exactly once across the two ports.
6. Reset mid-operation and wrap: assert reset while all hold_v=1 -> outputs return to reset values immediately and no held byte is emitted after release. Preload tx_count to FFFF (via a bench force) and send one byte -> tx_count=0000.
